wb_port_arbiter: RTL
====================

# wb_port_arbiter

Shares the register file's single write port between the MEM/WB writeback stream and results returned by a long-latency multiply/divide unit (MDU). The MEM/WB stream has priority, and each MDU result is buffered in a small FIFO until the port is free. A starvation counter requests a one-cycle pipeline bubble when MDU results have waited too long. The block sits between the MEM/WB register outputs, the MDU result interface and the register file write port.

## Interface
Parameters:
- DATA_W, 32, write data width
- REG_W, 5, register address width
- DEPTH, 2, MDU result FIFO entries; power of two, ≥2
- STARVE_MAX, 4, wait cycles of a non-empty FIFO before a bubble is requested; ≥1

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  clock; all state updates on posedge
- RSTn  in  1  asynchronous active-low reset
- wb_regwrite  in  1  MEM/WB RegWrite
- wb_memtoreg  in  1  MEM/WB MemtoReg; 1 selects wb_readdata
- wb_aluout  in  DATA_W  MEM/WB ALU result
- wb_readdata  in  DATA_W  MEM/WB load data
- wb_writereg  in  REG_W  MEM/WB destination register
- mdu_valid  in  1  MDU result offered
- mdu_ready  out  1  FIFO can accept; equals (count < DEPTH); depends only on state
- mdu_result  in  DATA_W  MDU result data
- mdu_dest  in  REG_W  MDU destination register
- rf_we  out  1  register file write enable
- rf_waddr  out  REG_W  register file write address
- rf_wdata  out  DATA_W  register file write data
- rf_src  out  1  0 = pipeline source, 1 = FIFO head source
- mdu_pending  out  1  FIFO non-empty; used by the hazard unit
- stall  out  1  registered bubble request to the upstream pipeline

## Operation
- Write port selection is combinational and evaluated each cycle:
  - If wb_regwrite=1: the pipeline writes. rf_we=1, rf_waddr=wb_writereg, rf_wdata=wb_memtoreg ? wb_readdata : wb_aluout, rf_src=0.
  - Else if FIFO is non-empty: the FIFO head writes. rf_we=1, rf_waddr/rf_wdata come from the head entry, rf_src=1, and the head is dequeued at the edge.
  - Else: rf_we=0, rf_src=0, and rf_waddr/rf_wdata are driven to 0.
- Enqueue happens when mdu_valid && mdu_ready.
  - An entry with mdu_dest=0 is handshaken but not stored, and count does not change.
- Simultaneous enqueue and dequeue leave count unchanged. Pointers wrap modulo DEPTH.
- mdu_ready is computed from the count before the edge. A full FIFO therefore deasserts ready even in a cycle where it dequeues.
- There is no bypass. An MDU result reaches the register file no earlier than the cycle after its acceptance.
- Results drain in FIFO order.
- Write-after-write ordering between MDU and pipeline writes to the same register is the hazard unit's job (via mdu_pending). This block does not check it.
- Starvation counter starve_cnt, width clog2(STARVE_MAX+1):
  - 0 when FIFO is empty after the edge, or when a dequeue occurs.
  - Otherwise it increments each cycle, saturating at STARVE_MAX.
- stall is the register (starve_cnt_next == STARVE_MAX && FIFO non-empty after the edge).
  - The upstream pipeline responds with a bubble (wb_regwrite=0) in a following cycle, which drains the head.
  - If the pipeline keeps presenting writes, it still wins the port, and stall stays high until a dequeue.
- mdu_pending = (count != 0).

## Timing
- Reset (RSTn low, asynchronous):
  - count=0, pointers=0, starve_cnt=0, stall=0, FIFO contents discarded.
  - Resulting outputs: mdu_ready=1, mdu_pending=0, and rf_* follow wb_* combinationally.
- Reset asserted mid-operation drops all buffered MDU results.
- Deassertion of RSTn takes effect at the next posedge.
- Pipeline write latency is 0: combinational passthrough in the same cycle as the MEM/WB output.
- MDU write latency:
  - 1 cycle minimum, from the acceptance edge to rf_we with rf_src=1.
  - Worst case with a continuously busy pipeline: unbounded until the bubble arrives.
- stall rises on the edge where starve_cnt reaches STARVE_MAX, i.e. STARVE_MAX cycles after the head first waits. It falls on the edge of the dequeue.
- Full FIFO (count=DEPTH): mdu_ready=0. It returns to 1 the cycle after a dequeue.
- Empty FIFO with wb_regwrite=0: rf_we=0, and starve_cnt holds 0.

## Test plan
- Pipeline only: wb_regwrite=1, wb_writereg=3, wb_memtoreg=1, wb_readdata=0xDEADBEEF, no MDU traffic -> rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF, rf_src=0 in the same cycle; stall stays 0.
- MDU on idle port: mdu_valid one cycle with dest=7, result=0x1234, wb_regwrite=0 -> next cycle rf_we=1, rf_waddr=7, rf_wdata=0x1234, rf_src=1; mdu_pending returns to 0 after that edge.
- Fill and backpressure, DEPTH=2:
  - Stimulus: wb_regwrite held 1, three MDU results offered back-to-back.
  - Required: the first two are accepted; mdu_ready=0 on the third; stall rises 4 cycles after the first wait.
  - Then drop wb_regwrite: the FIFO drains in order over 2 cycles, stall falls, and mdu_ready returns to 1.
- Simultaneous events and dest 0:
  - Dequeue and enqueue in the same cycle: count unchanged, order preserved.
  - mdu_dest=0 is accepted, never written, and count stays 0.
- Reset mid-operation: RSTn pulsed low between edges with 2 entries and stall=1 -> immediately mdu_pending=0, stall=0, mdu_ready=1; no MDU write occurs afterwards.
- Pointer wrap: 10 enqueue/dequeue pairs with distinct dests 1..10 -> rf writes appear in order 1..10 with matching data.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register file write port arbiter between MEM/WB and buffered MDU results
module wb_port_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_W      = 5,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              wb_regwrite,
    input  logic              wb_memtoreg,
    input  logic [DATA_W-1:0] wb_aluout,
    input  logic [DATA_W-1:0] wb_readdata,
    input  logic [REG_W-1:0]  wb_writereg,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [DATA_W-1:0] mdu_result,
    input  logic [REG_W-1:0]  mdu_dest,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_src,
    output logic              mdu_pending,
    output logic              stall
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ST_W  = $clog2(STARVE_MAX + 1);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [REG_W-1:0]  dest_q [DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ST_W-1:0]  starve_q, starve_d;
    logic             stall_q, stall_d;

    logic accept;
    logic enq;
    logic deq;

    assign mdu_ready   = (count_q < CNT_W'(DEPTH));
    assign mdu_pending = (count_q != '0);
    assign stall       = stall_q;

    // A zero destination completes the handshake but is never stored.
    assign accept = mdu_valid && mdu_ready;
    assign enq    = accept && (mdu_dest != '0);
    assign deq    = !wb_regwrite && mdu_pending;

    always_comb begin
        rf_we    = 1'b0;
        rf_src   = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (wb_regwrite) begin
            rf_we    = 1'b1;
            rf_waddr = wb_writereg;
            rf_wdata = wb_memtoreg ? wb_readdata : wb_aluout;
        end else if (mdu_pending) begin
            rf_we    = 1'b1;
            rf_src   = 1'b1;
            rf_waddr = dest_q[rptr_q];
            rf_wdata = data_q[rptr_q];
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (enq) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (deq) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // The wait counter restarts whenever the head moves or the FIFO empties.
    always_comb begin
        starve_d = starve_q;
        if ((count_d == '0) || deq) begin
            starve_d = '0;
        end else if (starve_q != ST_W'(STARVE_MAX)) begin
            starve_d = starve_q + ST_W'(1);
        end
        stall_d = (starve_d == ST_W'(STARVE_MAX)) && (count_d != '0);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (enq) begin
            data_q[wptr_q] <= mdu_result;
            dest_q[wptr_q] <= mdu_dest;
        end
    end
endmodule
